store_buffer: RTL and testbench

- In-order write buffer between the MEM pipeline stage and the byte-enabled data memory.
- Accepts committed stores (address, data, byte enables, PC) into a small FIFO and drains one per cycle into the memory write port whenever the memory grants a slot.
- Loads that hit a pending store word raise a stall until that entry has drained. The memory read path never returns stale data.

---
 rtl/store_buffer.sv | 88 ++++++++
 tb/tb_store_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order store buffer between the MEM stage and byte-enabled data memory.
// Drains one entry per granted cycle and stalls loads that hit a pending store word.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wd,
  input  logic [3:0]       st_be,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_stall,
  input  logic             mem_ready,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic [31:0]      mem_pc,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      wd_q    [DEPTH];
  logic [3:0]       be_q    [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             push;
  logic             pop;
  logic             hit;

  assign empty    = (count == '0);
  assign st_ready = (count != FULL_COUNT);
  assign push     = st_valid && st_ready && (st_be != 4'b0000);
  // Reset suppresses the write strobe so discarded stores never reach memory.
  assign mem_we   = !empty && mem_ready && !reset;
  assign pop      = mem_we;

  assign mem_be   = empty ? 4'b0000 : be_q[head];
  assign mem_addr = empty ? 32'h0   : addr_q[head];
  assign mem_wd   = empty ? 32'h0   : wd_q[head];
  assign mem_pc   = empty ? 32'h0   : pc_q[head];

  // Word-granular hazard check; the incoming store counts even if not accepted.
  always_comb begin
    hit = st_valid && (st_addr[31:2] == ld_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_stall = ld_valid && hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        addr_q[tail]  <= st_addr;
        wd_q[tail]    <= st_wd;
        be_q[tail]    <= st_be;
        pc_q[tail]    <= st_pc;
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        mem_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [2:0]  count;
  logic        empty;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [3:0]  be;
  } ent_t;

  ent_t model_q[$];

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wd(st_wd), .st_be(st_be), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .mem_ready(mem_ready), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_pc(mem_pc), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of pending stores.
  function automatic logic m_stall();
    logic h;
    h = st_valid && (st_addr[31:2] == ld_addr[31:2]);
    foreach (model_q[i]) if (model_q[i].addr[31:2] == ld_addr[31:2]) h = 1'b1;
    return ld_valid && h;
  endfunction

  function automatic logic m_we();
    return !reset && (model_q.size() > 0) && mem_ready;
  endfunction

  function automatic ent_t m_head();
    ent_t e;
    e = '0;
    if (model_q.size() > 0) e = model_q[0];
    return e;
  endfunction

  task automatic tick();
    logic do_push, do_pop;
    ent_t e;
    do_pop  = m_we();
    do_push = st_valid && (model_q.size() < DEPTH) && (st_be != 4'b0000);
    e.addr = st_addr; e.wd = st_wd; e.pc = st_pc; e.be = st_be;
    @(posedge clk);
    if (reset) begin
      model_q.delete();
    end else begin
      if (do_pop) model_q.delete(0);
      if (do_push) model_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be, input logic [31:0] pc);
    st_valid = sv; st_addr = a; st_wd = wd; st_be = be; st_pc = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    tick(); tick();
    reset = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h40;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_cmp++; if (st_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_st_ready: got %b expected 1", st_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
    n_cmp++; if (ld_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ld_stall: got %b expected 0", ld_stall); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_mem_fields: got addr %h be %h expected 0", mem_addr, mem_be); end
    ld_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_store();
    mem_ready = 1'b1;
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h3000);
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_bypass: got mem_we %b expected 0", mem_we); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL single_we: got %b expected 1", mem_we); end
    n_cmp++; if (mem_addr !== 32'h10) begin n_fail++; $display("[TB] FAIL single_addr: got %h expected 10", mem_addr); end
    n_cmp++; if (mem_wd !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_wd: got %h expected deadbeef", mem_wd); end
    n_cmp++; if (mem_pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL single_pc: got %h expected 3000", mem_pc); end
    n_cmp++; if (mem_be !== 4'hF) begin n_fail++; $display("[TB] FAIL single_be: got %h expected f", mem_be); end
    tick();
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL single_empty_after: got %b expected 1", empty); end
  endtask

  task automatic test_fill();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 32'h4000 + 32'(i * 4));
      tick();
    end
    applyStimulus(1'b1, 32'h50, 32'h5555, 4'hF, 32'h4010);
    #1;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
    n_cmp++; if (st_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_st_ready: got %b expected 0", st_ready); end
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_drop_fifth: got count %0d expected 4", count); end
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== 32'(i * 4)) begin
        n_fail++; $display("[TB] FAIL fill_drain_%0d: got we %b addr %h expected we 1 addr %h", i, mem_we, mem_addr, 32'(i * 4));
      end
      tick();
    end
    #1;
    n_cmp++; if (st_ready !== 1'b1 || empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_after_drain: got st_ready %b empty %b expected 1 1", st_ready, empty); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pushed[$];
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pushed.push_back(32'h200 + 32'(i * 8));
      applyStimulus(1'b1, pushed[i], $urandom, 4'(1 + $urandom_range(0, 14)), $urandom);
      #1;
      if (i > 0) begin
        n_cmp++;
        if (count !== 3'd1 || mem_we !== 1'b1 || mem_addr !== pushed[i-1]) begin
          n_fail++; $display("[TB] FAIL b2b_%0d: got count %0d we %b addr %h expected 1 1 %h", i, count, mem_we, mem_addr, pushed[i-1]);
        end
      end
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    #1;
    n_cmp++; if (mem_addr !== pushed[5] || count !== 3'd1) begin n_fail++; $display("[TB] FAIL b2b_last: got addr %h count %0d expected %h 1", mem_addr, count, pushed[5]); end
    tick();
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  task automatic test_load_hazard();
    mem_ready = 1'b0;
    applyStimulus(1'b1, 32'h20, 32'h000000AA, 4'b0001, 32'h5000);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    ld_valid = 1'b1; ld_addr = 32'h23;
    #1;
    n_cmp++; if (ld_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL hazard_hit: got %b expected 1", ld_stall); end
    ld_addr = 32'h24;
    #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL hazard_miss: got %b expected 0", ld_stall); end
    ld_addr = 32'h23; mem_ready = 1'b1;
    #1;
    n_cmp++; if (ld_stall !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("[TB] FAIL hazard_draining: got stall %b we %b expected 1 1", ld_stall, mem_we); end
    tick();
    #1;
    n_cmp++; if (ld_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL hazard_release: got %b expected 0", ld_stall); end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA000 + 32'(i * 4), $urandom, 4'hF, $urandom);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_we: got %b expected 0", mem_we); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d expected 0", count); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== 32'h0) begin
        n_fail++; $display("[TB] FAIL midreset_ghost_%0d: got we %b addr %h expected 0 0", i, mem_we, mem_addr);
      end
      tick();
    end
  endtask

  task automatic test_random();
    ent_t h;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      applyStimulus($urandom_range(0, 1) == 1, 32'h100 + 32'($urandom_range(0, 31)), $urandom,
                    4'($urandom_range(0, 15)), $urandom);
      ld_valid = $urandom_range(0, 1) == 1;
      ld_addr = 32'h100 + 32'($urandom_range(0, 31));
      #1;
      h = m_head();
      n_cmp++; if (count !== 3'(model_q.size())) begin n_fail++; $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", c, count, model_q.size()); end
      n_cmp++; if (empty !== (model_q.size() == 0)) begin n_fail++; $display("[TB] FAIL rnd_empty@%0d: got %b", c, empty); end
      n_cmp++; if (st_ready !== (model_q.size() != DEPTH)) begin n_fail++; $display("[TB] FAIL rnd_st_ready@%0d: got %b", c, st_ready); end
      n_cmp++; if (mem_we !== m_we()) begin n_fail++; $display("[TB] FAIL rnd_mem_we@%0d: got %b expected %b", c, mem_we, m_we()); end
      n_cmp++; if (ld_stall !== m_stall()) begin n_fail++; $display("[TB] FAIL rnd_ld_stall@%0d: got %b expected %b", c, ld_stall, m_stall()); end
      n_cmp++;
      if (mem_addr !== h.addr || mem_wd !== h.wd || mem_pc !== h.pc || mem_be !== h.be) begin
        n_fail++; $display("[TB] FAIL rnd_head@%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", c,
                           mem_addr, mem_wd, mem_pc, mem_be, h.addr, h.wd, h.pc, h.be);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; ld_valid = 1'b0; ld_addr = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    test_reset();
    test_single_store();
    test_fill();
    test_back_to_back();
    test_load_hazard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
